// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the RAM access controller.
// Build option: RAM_CLEAR_EN adds the post-reset CLEAR state.
package ram_ctrl_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 6;

  typedef enum logic [2:0] {
`ifdef RAM_CLEAR_EN
    ST_CLEAR,
`endif
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RSP
  } state_e;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Host request/response and RAM-side signal bundle for ram_access_ctrl.
interface ram_access_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_write_addr;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_q,
    output req_ready, rsp_valid, rsp_rdata,
    output ram_we, ram_write_addr, ram_data, ram_read_addr
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_q,
    input  req_ready, rsp_valid, rsp_rdata,
    input  ram_we, ram_write_addr, ram_data, ram_read_addr
  );

endinterface

// File: rtl/ram_access_ctrl.sv
// Single-port-style host front end for an external synchronous RAM (1-cycle read).
// Build option: RAM_CLEAR_EN zero-fills the RAM after every reset.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_access_ctrl_if.slave    bus,
  output logic                busy
);

`ifdef RAM_CLEAR_EN
  localparam state_e RST_STATE = ST_CLEAR;
  logic [ADDR_W-1:0] r_clr_cnt;
`else
  localparam state_e RST_STATE = ST_IDLE;
`endif

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_waddr;
  logic [DATA_W-1:0] r_ram_data;
  logic [ADDR_W-1:0] r_ram_raddr;
  logic              r_busy;

  // r_req_ready is only ever set while entering IDLE, so it alone gates acceptance
  assign w_wr_acc = bus.req_valid & r_req_ready & bus.req_we;
  assign w_rd_acc = bus.req_valid & r_req_ready & ~bus.req_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RST_STATE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
`ifdef RAM_CLEAR_EN
      ST_CLEAR:    if (r_clr_cnt == {ADDR_W{1'b1}}) w_state_nxt = ST_IDLE;
`endif
      ST_IDLE:     if (w_rd_acc) w_state_nxt = ST_RD_ISSUE;
      ST_RD_ISSUE: w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:  w_state_nxt = ST_RSP;
      ST_RSP:      if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered host handshake and RAM-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b0;
      r_busy      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_ram_we    <= 1'b0;
      r_ram_waddr <= '0;
      r_ram_data  <= '0;
      r_ram_raddr <= '0;
`ifdef RAM_CLEAR_EN
      r_clr_cnt   <= '0;
`endif
    end else begin
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_ram_we    <= w_wr_acc;
      if (w_wr_acc) begin
        r_ram_waddr <= bus.req_addr;
        r_ram_data  <= bus.req_wdata;
      end
      if (w_rd_acc) r_ram_raddr <= bus.req_addr;
      if (r_state == ST_RD_WAIT) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= bus.ram_q;
      end else if (r_state == ST_RSP && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
`ifdef RAM_CLEAR_EN
      if (r_state == ST_CLEAR) begin
        r_ram_we    <= 1'b1;
        r_ram_waddr <= r_clr_cnt;
        r_ram_data  <= '0;
        r_clr_cnt   <= r_clr_cnt + ADDR_W'(1);
      end
`endif
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_rdata      = r_rsp_rdata;
  assign bus.ram_we         = r_ram_we;
  assign bus.ram_write_addr = r_ram_waddr;
  assign bus.ram_data       = r_ram_data;
  assign bus.ram_read_addr  = r_ram_raddr;
  assign busy               = r_busy;

endmodule
